inv_mix_col_dec: RTL and testbench



---
 rtl/inv_mix_col_dec.sv | 122 ++++++++++++
 tb/tb_inv_mix_col_dec.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_col_dec.sv
// Iterative AES-128 InvMixColumns: one shared column unit, one column per cycle.
// Define INV_MIX_COL_PARALLEL_EN to use four column units and finish in one cycle.
module inv_mix_col_dec #(
    parameter int NUM_COLS = 4
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] DataIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] DataOut,
    output logic [1:0]   DbgState
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready in the same cycle.

    localparam int CNT_W = $clog2(NUM_COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       data_q, data_d;
    logic [31:0]        cols [NUM_COLS];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 09 = 8+1, 0B = 8+2+1, 0D = 8+4+1, 0E = 8+4+2, all from one xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            cols[c] = data_q[127-32*c -: 32];
        end
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    data_d  = DataIn;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef INV_MIX_COL_PARALLEL_EN
                for (int c = 0; c < NUM_COLS; c++) begin
                    data_d[127-32*c -: 32] = inv_mix_col(cols[c]);
                end
                state_d = DONE;
`else
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (cnt_q == CNT_W'(c)) begin
                        data_d[127-32*c -: 32] = inv_mix_col(cols[cnt_q]);
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_COLS - 1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Status outputs decode the state register so reset clears them at once.
    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign DataOut  = data_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_inv_mix_col_dec.sv
// Directed bench for inv_mix_col_dec using FIPS-197 InvMixColumns column vectors.
// Compile with INV_MIX_COL_PARALLEL_EN to check the single-cycle variant.
module tb_inv_mix_col_dec;

`ifdef INV_MIX_COL_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int PERIOD = LAT + 2;

    logic         Clk;
    logic         RstN;
    logic         InValid;
    logic         InReady;
    logic [127:0] DataIn;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] DataOut;
    logic [1:0]   DbgState;

    int n_cmp;
    int n_fail;
    logic [127:0] exp_q[$];

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;
    localparam logic [127:0] V3_IN  = 128'h01010101_8e4da1bc_c6c6c6c6_9fdc589d;
    localparam logic [127:0] V3_OUT = 128'h01010101_db135345_c6c6c6c6_f20a225c;
    localparam logic [127:0] ONES   = {128{1'b1}};

    inv_mix_col_dec #(.NUM_COLS(4)) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .InValid  (InValid),
        .InReady  (InReady),
        .DataIn   (DataIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .DataOut  (DataOut),
        .DbgState (DbgState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic test_reset;
        RstN     = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        DataIn   = '0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || DataOut !== 128'h0 || DbgState !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b out=%h st=%0d want rdy=1 vld=0 out=0 st=0",
                     InReady, OutValid, DataOut, DbgState);
        end
        RstN = 1'b1;
    endtask

    // Accepts din on the next edge, checks latency, result and output handshake.
    task automatic run_vec(input string name, input logic [127:0] din, input logic [127:0] expd);
        int cyc;
        n_cmp++;
        if (InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b want 1", name, InReady);
        end
        InValid  = 1'b1;
        DataIn   = din;
        OutReady = 1'b0;
        @(negedge Clk);
        InValid = 1'b0;
        DataIn  = 128'hx;
        cyc = 0;
        while (OutValid !== 1'b1 && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            DataIn = {$urandom, $urandom, $urandom, $urandom};
        end
        n_cmp++;
        if (cyc !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, LAT);
        end
        n_cmp++;
        if (DataOut !== expd) begin
            n_fail++;
            $display("FAIL %s_data: got %h want %h", name, DataOut, expd);
        end
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handshake: vld=%b rdy=%b want vld=0 rdy=1", name, OutValid, InReady);
        end
    endtask

    task automatic test_reset_mid_busy;
        InValid = 1'b1;
        DataIn  = V2_IN;
        @(negedge Clk);
        InValid = 1'b0;
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        n_cmp++;
        if (OutValid !== 1'b0 || DataOut !== 128'h0 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: vld=%b out=%h rdy=%b want vld=0 out=0 rdy=1",
                     OutValid, DataOut, InReady);
        end
        @(negedge Clk);
        RstN = 1'b1;
        run_vec("after_reset", V1_IN, V1_OUT);
    endtask

    task automatic test_backpressure;
        int cyc;
        InValid = 1'b1;
        DataIn  = V2_IN;
        @(negedge Clk);
        InValid = 1'b0;
        cyc = 0;
        while (OutValid !== 1'b1 && cyc < 20) begin
            @(negedge Clk);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1;
            DataIn  = V1_IN;
            @(negedge Clk);
            n_cmp++;
            if (OutValid !== 1'b1 || InReady !== 1'b0 || DataOut !== V2_OUT) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b out=%h want vld=1 rdy=0 out=%h",
                         i, OutValid, InReady, DataOut, V2_OUT);
            end
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || DataOut !== V2_OUT) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b out=%h want vld=0 rdy=1 out=%h",
                     OutValid, InReady, DataOut, V2_OUT);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        logic [127:0] e;
        int idx;
        int got;
        int last_cyc;
        vin[0] = V1_IN;  vexp[0] = V1_OUT;
        vin[1] = V3_IN;  vexp[1] = V3_OUT;
        vin[2] = V2_IN;  vexp[2] = V2_OUT;
        OutReady = 1'b1;
        InValid  = 1'b1;
        DataIn   = vin[0];
        exp_q.push_back(vexp[0]);
        idx = 1;
        got = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clk);
            if (OutValid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got %h want no result", DataOut);
                end else begin
                    e = exp_q.pop_front();
                    if (DataOut !== e) begin
                        n_fail++;
                        $display("FAIL b2b_data%0d: got %h want %h", got, DataOut, e);
                    end
                end
                if (got > 0) begin
                    n_cmp++;
                    if (cyc - last_cyc !== PERIOD) begin
                        n_fail++;
                        $display("FAIL b2b_period%0d: got %0d want %0d", got, cyc - last_cyc, PERIOD);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (InReady === 1'b1) begin
                if (idx < 3) begin
                    DataIn = vin[idx];
                    exp_q.push_back(vexp[idx]);
                    idx++;
                end else begin
                    InValid = 1'b0;
                end
            end
        end
        InValid  = 1'b0;
        OutReady = 1'b0;
        n_cmp++;
        if (got !== 3 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, %0d pending, want 3 and 0", got, exp_q.size());
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        run_vec("fips_cols", V1_IN, V1_OUT);
        test_reset_mid_busy();
        run_vec("round_trip", V2_IN, V2_OUT);
        run_vec("col_order", V3_IN, V3_OUT);
        run_vec("all_zero", 128'h0, 128'h0);
        run_vec("all_ff", ONES, ONES);
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
